reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  Integer register file and writeback stage that consumes the ALU result
//  (rd_write_control / rd_write_val). It registers each result for one cycle,
//  then commits it to the register array. It serves rs1_val / rs2_val to the
//  ALU, bypassing the commit in flight, and keeps a per-register busy
//  scoreboard that stalls issue on RAW and WAW hazards.
// PARAMETERS
//  XLEN    32  data width of registers and ALU results
//  NREGS   32  number of architectural registers; x0 is hardwired to zero
//  AW      5   register address width, clog2(NREGS)
//  BYPASS  1   1: reads see the value being committed this cycle; 0: they do not
// PORTS
//  clk               in   1     clock, rising edge
//  rst_n             in   1     asynchronous reset, active-low
//  issue_valid       in   1     decoder presents an instruction for issue
//  issue_ready       out  1     no hazard; issue handshake = issue_valid & issue_ready
//  issue_rs1_addr    in   AW    source 1 register index
//  issue_rs2_addr    in   AW    source 2 register index
//  issue_rd_addr     in   AW    destination register index
//  issue_rd_en       in   1     instruction will write rd
//  rs1_val           out  XLEN  source 1 operand to ALU (combinational)
//  rs2_val           out  XLEN  source 2 operand to ALU (combinational)
//  ex_valid          in   1     ALU result valid this cycle
//  ex_rd_addr        in   AW    destination of ALU result
//  rd_write_control  in   1     ALU requests a write of rd
//  rd_write_val      in   XLEN  ALU result
//  wb_valid          out  1     writeback stage holds a result (retire strobe)
//  wb_we             out  1     writeback stage will write the array
//  wb_rd_addr        out  AW    writeback destination
//  wb_rd_val         out  XLEN  writeback value
// BEHAVIOUR
//  Reset (async, rst_n=0): every register = 0; busy[] = 0; wb_valid = 0;
//    wb_we = 0; wb_rd_addr = 0; wb_rd_val = 0. Therefore rs1_val = rs2_val = 0.
//    Reset asserted mid-operation discards the in-flight result and all busy bits.
//  WB stage: each edge loads wb_valid <= ex_valid,
//    wb_we <= ex_valid & rd_write_control, wb_rd_addr <= ex_rd_addr,
//    wb_rd_val <= rd_write_val. When ex_valid = 0, wb_we is 0.
//  Commit: on an edge with wb_we = 1 and wb_rd_addr != 0, regs[wb_rd_addr] <= wb_rd_val.
//    A write to x0 is dropped. Result latency is ex_valid -> array updated 2 edges later.
//  Read: rs_val = 0 if addr == 0.
//    Else, with BYPASS = 1 and wb_we = 1 and wb_rd_addr == addr: rs_val = wb_rd_val.
//    Else rs_val = regs[addr].
//  Scoreboard: on an issue handshake with issue_rd_en = 1 and rd != 0, set busy[rd].
//    On an edge with wb_valid = 1, clear busy[wb_rd_addr].
//    If set and clear target the same index in the same cycle, set wins.
//  Hazard: a register r is "pending" if busy[r] = 1 and not (BYPASS = 1 & wb_valid = 1 &
//    wb_rd_addr == r). issue_ready = 0 when any of the following hold:
//    - rs1 != 0 and rs1 is pending;
//    - rs2 != 0 and rs2 is pending;
//    - issue_rd_en = 1 and rd != 0 and rd is pending.
//    Otherwise issue_ready = 1. issue_ready is independent of issue_valid.
//  The block does not check ex_valid for an unissued rd. The ALU produces exactly one
//    ex_valid per issued instruction, in order.
// TESTING
//  1 Reset: rst_n=0 mid-run with busy[5]=1 and wb_valid=1 -> all outputs 0, busy cleared,
//    regs[5] reads 0 after release.
//  2 Write/read: ex_valid=1, rd_write_control=1, ex_rd_addr=3, rd_write_val=0xDEADBEEF.
//    Then rs1_addr=3 -> rs1_val=0xDEADBEEF in the wb cycle (bypass) and every later cycle.
//  3 x0: write 0x12345678 to rd=0 -> rs1_addr=0 reads 0. Issue with rd=0 never sets busy
//    and never stalls.
//  4 RAW stall: issue rd=7, then issue rs2=7 -> issue_ready=0 until wb_valid & wb_rd_addr=7.
//    That cycle ready=1 and rs2_val = wb_rd_val. With BYPASS=0, ready=1 one cycle later.
//  5 Simultaneous set/clear: wb clears x9 on the same edge that a new issue with rd=9
//    handshakes -> busy[9]=1 afterwards.
//  6 No-write result: ex_valid=1, rd_write_control=0, rd=4 -> regs[4] unchanged,
//    busy[4] cleared, wb_valid=1, wb_we=0.

Source files
------------

// File: rtl/reg_file_wb.sv
// Integer register file with a one-cycle writeback register, commit bypass
// and a per-register busy scoreboard for RAW/WAW issue stalls.
module reg_file_wb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   issue_rs1_addr,
  input  logic [AW-1:0]   issue_rs2_addr,
  input  logic [AW-1:0]   issue_rd_addr,
  input  logic            issue_rd_en,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_rd_addr,
  input  logic            rd_write_control,
  input  logic [XLEN-1:0] rd_write_val,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [AW-1:0]   wb_rd_addr,
  output logic [XLEN-1:0] wb_rd_val
);

  localparam bit BypassOn = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wb_valid_q;
  logic             wb_we_q;
  logic [AW-1:0]    wb_rd_addr_q;
  logic [XLEN-1:0]  wb_rd_val_q;
  logic             issue_fire;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             haz_rd;

  function automatic logic [XLEN-1:0] rd_port(
    input logic [AW-1:0] a
  );
    if (a == '0)
      return '0;
    if (BypassOn && wb_we_q && wb_rd_addr_q == a)
      return wb_rd_val_q;
    return regs_q[a];
  endfunction

  // A register retiring this cycle is not pending once bypass covers it.
  function automatic logic pend(
    input logic [AW-1:0] a
  );
    return busy_q[a] &&
      !(BypassOn && wb_valid_q && wb_rd_addr_q == a);
  endfunction

  assign rs1_val = rd_port(issue_rs1_addr);
  assign rs2_val = rd_port(issue_rs2_addr);

  assign haz_rs1 = (issue_rs1_addr != '0) &&
                   pend(issue_rs1_addr);
  assign haz_rs2 = (issue_rs2_addr != '0) &&
                   pend(issue_rs2_addr);
  assign haz_rd  = issue_rd_en &&
                   (issue_rd_addr != '0) &&
                   pend(issue_rd_addr);

  assign issue_ready = !(haz_rs1 || haz_rs2 || haz_rd);
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    busy_d = busy_q;
    if (wb_valid_q)
      busy_d[wb_rd_addr_q] = 1'b0;
    if (issue_fire && issue_rd_en &&
        issue_rd_addr != '0)
      busy_d[issue_rd_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_rd_val_q  <= '0;
    end else begin
      busy_q       <= busy_d;
      wb_valid_q   <= ex_valid;
      wb_we_q      <= ex_valid && rd_write_control;
      wb_rd_addr_q <= ex_rd_addr;
      wb_rd_val_q  <= rd_write_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wb_we_q && wb_rd_addr_q != '0) begin
      regs_q[wb_rd_addr_q] <= wb_rd_val_q;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_rd_val  = wb_rd_val_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: ALU results go to a scoreboard queue popped by a
// writeback monitor; operand reads and issue stalls are checked inline.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1_addr;
  logic [4:0]  issue_rs2_addr;
  logic [4:0]  issue_rd_addr;
  logic        issue_rd_en;
  logic        ex_valid;
  logic [4:0]  ex_rd_addr;
  logic        rd_write_control;
  logic [31:0] rd_write_val;

  logic        issue_ready;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_val;

  logic        nb_ready;
  logic [31:0] nb_rs1;
  logic [31:0] nb_rs2;
  logic        nb_valid;
  logic        nb_we;
  logic [4:0]  nb_addr;
  logic [31:0] nb_val;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  reg_file_wb #(.BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_rs1_addr(issue_rs1_addr),
    .issue_rs2_addr(issue_rs2_addr),
    .issue_rd_addr(issue_rd_addr),
    .issue_rd_en(issue_rd_en),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .ex_valid(ex_valid),
    .ex_rd_addr(ex_rd_addr),
    .rd_write_control(rd_write_control),
    .rd_write_val(rd_write_val),
    .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd_addr(wb_rd_addr),
    .wb_rd_val(wb_rd_val)
  );

  reg_file_wb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_ready(nb_ready),
    .issue_rs1_addr(issue_rs1_addr),
    .issue_rs2_addr(issue_rs2_addr),
    .issue_rd_addr(issue_rd_addr),
    .issue_rd_en(issue_rd_en),
    .rs1_val(nb_rs1), .rs2_val(nb_rs2),
    .ex_valid(ex_valid),
    .ex_rd_addr(ex_rd_addr),
    .rd_write_control(rd_write_control),
    .rd_write_val(rd_write_val),
    .wb_valid(nb_valid), .wb_we(nb_we),
    .wb_rd_addr(nb_addr),
    .wb_rd_val(nb_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid      = 1'b0;
    issue_rs1_addr   = '0;
    issue_rs2_addr   = '0;
    issue_rd_addr    = '0;
    issue_rd_en      = 1'b0;
    ex_valid         = 1'b0;
    ex_rd_addr       = '0;
    rd_write_control = 1'b0;
    rd_write_val     = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic ex(logic w, logic [4:0] a,
                    logic [31:0] v);
    exp_t e;
    ex_valid         = 1'b1;
    rd_write_control = w;
    ex_rd_addr       = a;
    rd_write_val     = v;
    e.we = w;
    e.a  = a;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic iss(logic vld, logic [4:0] s1,
                     logic [4:0] s2, logic [4:0] d,
                     logic en);
    issue_valid    = vld;
    issue_rs1_addr = s1;
    issue_rs2_addr = s2;
    issue_rd_addr  = d;
    issue_rd_en    = en;
  endtask

  // Writeback monitor: every retire strobe must match the next queued result.
  always @(negedge clk) begin
    #2;
    if (rst_n && wb_valid) begin
      if (q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
        chk("wb_addr", {27'd0, wb_rd_addr},
            {27'd0, e.a});
        chk("wb_val", wb_rd_val, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_val", wb_rd_val, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    nxt();
    nxt();
    rst_n = 1'b1;

    // write x3, read via bypass then array
    nxt(); ex(1'b1, 5'd3, 32'hDEADBEEF);
    nxt(); iss(1'b0, 5'd3, 5'd0, 5'd0, 1'b0);
    #1;
    chk("byp_rs1", rs1_val, 32'hDEADBEEF);
    chk("nobyp_rs1", nb_rs1, 32'h0);
    nxt(); iss(1'b0, 5'd3, 5'd3, 5'd0, 1'b0);
    #1;
    chk("arr_rs1", rs1_val, 32'hDEADBEEF);
    chk("arr_rs2", rs2_val, 32'hDEADBEEF);
    chk("nb_arr_rs1", nb_rs1, 32'hDEADBEEF);

    // x0 writes dropped, rd=0 never stalls
    nxt(); ex(1'b1, 5'd0, 32'h12345678);
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("x0_byp", rs1_val, 32'h0);
    chk("x0_ready0", {31'd0, issue_ready}, 32'd1);
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("x0_arr", rs1_val, 32'h0);
    chk("x0_ready1", {31'd0, issue_ready}, 32'd1);

    // RAW stall on x7
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    chk("raw_issue_rd", {31'd0, issue_ready}, 32'd1);
    nxt(); iss(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
    #1;
    chk("raw_stall0", {31'd0, issue_ready}, 32'd0);
    chk("raw_nb_stall0", {31'd0, nb_ready}, 32'd0);
    nxt(); iss(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
    ex(1'b1, 5'd7, 32'h00000077);
    #1;
    chk("raw_stall1", {31'd0, issue_ready}, 32'd0);
    nxt(); iss(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
    #1;
    chk("raw_wb_ready", {31'd0, issue_ready}, 32'd1);
    chk("raw_wb_rs2", rs2_val, 32'h00000077);
    chk("raw_nb_wb_stall", {31'd0, nb_ready}, 32'd0);
    nxt(); iss(1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    #1;
    chk("raw_nb_ready", {31'd0, nb_ready}, 32'd1);
    chk("raw_nb_rs2", nb_rs2, 32'h00000077);

    // no-write result on x4
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    #1;
    chk("nw_issue", {31'd0, issue_ready}, 32'd1);
    nxt(); iss(1'b0, 5'd4, 5'd0, 5'd0, 1'b0);
    ex(1'b1, 5'd4, 32'h00000044);
    #1;
    chk("nw_busy", {31'd0, issue_ready}, 32'd0);
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    #1;
    chk("nw_waw_ok", {31'd0, issue_ready}, 32'd1);
    nxt(); iss(1'b0, 5'd4, 5'd0, 5'd0, 1'b0);
    ex(1'b0, 5'd4, 32'h00000099);
    #1;
    chk("nw_reset_busy", {31'd0, issue_ready}, 32'd0);
    chk("nw_rs1_a", rs1_val, 32'h00000044);
    nxt(); iss(1'b0, 5'd4, 5'd0, 5'd0, 1'b0);
    #1;
    chk("nw_rs1_wb", rs1_val, 32'h00000044);
    chk("nw_ready_wb", {31'd0, issue_ready}, 32'd1);
    nxt(); iss(1'b0, 5'd4, 5'd0, 5'd0, 1'b0);
    #1;
    chk("nw_rs1_b", rs1_val, 32'h00000044);
    chk("nw_cleared", {31'd0, issue_ready}, 32'd1);

    // set/clear collision on x9
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    nxt(); ex(1'b1, 5'd9, 32'h00000009);
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    #1;
    chk("sc_ready", {31'd0, issue_ready}, 32'd1);
    nxt(); iss(1'b0, 5'd9, 5'd0, 5'd0, 1'b0);
    #1;
    chk("sc_set_wins", {31'd0, issue_ready}, 32'd0);
    chk("sc_rs1", rs1_val, 32'h00000009);
    ex(1'b1, 5'd9, 32'h00000090);
    nxt(); nxt(); iss(1'b0, 5'd9, 5'd0, 5'd0, 1'b0);
    #1;
    chk("sc_done", {31'd0, issue_ready}, 32'd1);
    chk("sc_rs1_b", rs1_val, 32'h00000090);

    // async reset while x5 busy and wb_valid high
    nxt(); iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    nxt(); ex(1'b1, 5'd5, 32'h00000055);
    nxt(); iss(1'b0, 5'd5, 5'd3, 5'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("mr_wb_we", {31'd0, wb_we}, 32'd0);
    chk("mr_wb_addr", {27'd0, wb_rd_addr}, 32'd0);
    chk("mr_wb_val", wb_rd_val, 32'd0);
    chk("mr_rs1", rs1_val, 32'd0);
    chk("mr_rs2", rs2_val, 32'd0);
    nxt();
    rst_n = 1'b1;
    iss(1'b0, 5'd5, 5'd3, 5'd5, 1'b1);
    #1;
    chk("post_ready", {31'd0, issue_ready}, 32'd1);
    chk("post_rs1", rs1_val, 32'd0);
    chk("post_rs2", rs2_val, 32'd0);
    nxt(); nxt();
    chk("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
